nonce_collector: RTL
====================

Name: nonce_collector

Overview:
- Sits directly downstream of the hash/target comparator. It consumes the comparator's registered `found`, `busy` and byte-swapped `nonce` outputs.
- Buffers each winning nonce in a small first-word-fall-through FIFO and presents it to the host/control side over a valid/ready handshake.
- Keeps per-job statistics (hash attempts, finds) and flags overflow.
- A `flush` pulse starts a new job: it clears the buffer and statistics and latches a new job tag.

Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2.
- AW, 2, pointer width = log2(DEPTH).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- flush  in  1  new-job pulse; clears FIFO, counters, overflow, duplicate history.
- job_id  in  8  job tag, sampled when flush=1.
- found  in  1  comparator: hash below target (registered).
- busy  in  1  comparator: hash result valid this cycle (registered).
- nonce  in  32  comparator: nonce of current result, same cycle as found/busy.
- out_valid  out  1  FIFO non-empty; head entry valid.
- out_ready  in  1  consumer accepts head this cycle.
- out_nonce  out  32  head-of-FIFO nonce.
- out_job  out  8  current job tag.
- level  out  AW+1  number of entries held (0..DEPTH).
- overflow  out  1  sticky: a find was dropped because the FIFO was full.
- hash_cnt  out  32  busy cycles since last flush/reset; wraps mod 2^32.
- found_cnt  out  16  non-duplicate finds since last flush/reset; saturates at 0xFFFF.

Behaviour:
- Reset (rst=1 at clock edge) zeroes all of the following:
  - out_valid, out_nonce, out_job, level, overflow, hash_cnt, found_cnt.
  - The read/write pointers and the internal `last_valid` flag.
- rst has priority over flush; flush has priority over all other activity.
- Flush cycle:
  - Pointers, level, overflow, hash_cnt, found_cnt and last_valid all go to 0.
  - cur_job is loaded from job_id.
  - Any capture or pop in the same cycle is ignored.
  - out_valid=0 from the next cycle.
- Capture event:
  - cap = busy & found & ~flush.
  - dup = cap & last_valid & (nonce == last_nonce).
  - new = cap & ~dup.
- On every `new` event:
  - last_nonce←nonce, last_valid←1.
  - found_cnt increments, saturating at 0xFFFF.
  - found_cnt counts dropped finds too.
- Push and overflow:
  - push = new & (~full | pop).
  - If new & full & ~pop: the entry is dropped and overflow←1 (sticky until flush/reset).
- Pop: pop = out_valid & out_ready.
  - out_ready while empty has no effect.
- Simultaneous push and pop:
  - Both take effect; level unchanged.
  - When full, the popped slot is reused and no overflow occurs.
- level:
  - +1 on push only; −1 on pop only; unchanged otherwise.
  - full = (level==DEPTH); empty = (level==0).
- Pointers are AW bits and wrap from DEPTH−1 to 0.
- Latency:
  - A capture at edge N is visible at out_valid/out_nonce after edge N (one cycle).
  - out_nonce = mem[rd_ptr] whenever out_valid=1; it is held stable while out_valid & ~out_ready.
  - When empty, out_nonce holds its last value (0 after reset/flush).
- hash_cnt increments on every cycle with busy=1 and flush=0, regardless of found. It wraps from 0xFFFFFFFF to 0.
- out_job is the cur_job register.
- found without busy is ignored; the comparator's `found` is not gated by its input valid.

Test Plan:
- Reset/idle: after rst, drive busy=1, found=0 for 10 cycles -> hash_cnt=10, level=0, out_valid=0, found_cnt=0.
- Single find:
  - Stimulus: busy=found=1, nonce=0x12345678 for one cycle, out_ready=0.
  - Required: next cycle out_valid=1, out_nonce=0x12345678, level=1, found_cnt=1.
  - Then out_ready=1 for one cycle -> level=0, out_valid=0.
- Duplicate suppression:
  - Stimulus: same nonce 0xAAAA0001 with busy=found=1 for 3 consecutive cycles.
  - Required: level=1, found_cnt=1.
  - Then nonce 0xAAAA0002 -> level=2.
- Overflow (DEPTH=4):
  - Stimulus: push 5 distinct nonces (1..5) with out_ready=0.
  - Required: level=4, overflow=1, found_cnt=5.
  - Drain reads 1,2,3,4 in order.
  - Repeat with out_ready=1 held on the 5th capture -> overflow stays 0 and 5 is retained.
- Flush mid-operation:
  - Stimulus: with level=3, overflow=1, hash_cnt=20, assert flush with job_id=0x5C, plus a simultaneous capture and out_ready=1.
  - Required: next cycle level=0, overflow=0, hash_cnt=0, found_cnt=0, out_job=0x5C.
  - Re-presenting the last nonce is accepted as new (history cleared).
- Counter boundaries:
  - Preload via 0xFFFF distinct finds, or force in simulation, then one more find -> found_cnt stays 0xFFFF.
  - Force hash_cnt=0xFFFFFFFF, then one busy cycle -> hash_cnt=0.

Source files
------------

// File: rtl/nonce_collector.sv
// Collects winning nonces from the hash/target comparator into a small FWFT FIFO
// and keeps per-job hash/find statistics with sticky overflow reporting.
module nonce_collector #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic [7:0]    job_id,
  input  logic          found,
  input  logic          busy,
  input  logic [31:0]   nonce,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_nonce,
  output logic [7:0]    out_job,
  output logic [AW:0]   level,
  output logic          overflow,
  output logic [31:0]   hash_cnt,
  output logic [15:0]   found_cnt
);

  localparam logic [AW:0]   LVL_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [31:0]   last_nonce;
  logic          last_valid;
  logic [31:0]   last_out;
  logic [7:0]    cur_job;

  logic cap, dup, is_new, full, empty, pop, push, drop;

  always_comb begin
    cap    = 1'b0;
    dup    = 1'b0;
    is_new = 1'b0;
    full   = 1'b0;
    empty  = 1'b0;
    pop    = 1'b0;
    push   = 1'b0;
    drop   = 1'b0;
    cap    = busy & found & ~flush;
    dup    = cap & last_valid & (nonce == last_nonce);
    is_new = cap & ~dup;
    full   = (level == LVL_FULL);
    empty  = (level == '0);
    pop    = ~empty & out_ready & ~flush;
    push   = is_new & (~full | pop);
    drop   = is_new & full & ~pop;
  end

  // Handshake: head entry transfers on any rising edge where out_valid and out_ready are both high.
  assign out_valid = ~empty;
  // Head is read straight from storage; last_out keeps the display stable once drained.
  assign out_nonce = empty ? last_out : mem[rd_ptr];
  assign out_job   = cur_job;

  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= nonce;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      level      <= '0;
      overflow   <= 1'b0;
      hash_cnt   <= '0;
      found_cnt  <= '0;
      last_nonce <= '0;
      last_valid <= 1'b0;
      last_out   <= '0;
      cur_job    <= '0;
    end else if (flush) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      level      <= '0;
      overflow   <= 1'b0;
      hash_cnt   <= '0;
      found_cnt  <= '0;
      last_valid <= 1'b0;
      last_out   <= '0;
      cur_job    <= job_id;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) begin
        rd_ptr   <= rd_ptr + PTR_ONE;
        last_out <= mem[rd_ptr];
      end
      if (push && !pop)      level <= level + LVL_ONE;
      else if (pop && !push) level <= level - LVL_ONE;
      if (drop) overflow <= 1'b1;
      if (busy) hash_cnt <= hash_cnt + 32'd1;
      // Dropped finds still count, so found_cnt reflects what the comparator saw.
      if (is_new) begin
        last_nonce <= nonce;
        last_valid <= 1'b1;
        if (found_cnt != 16'hFFFF) found_cnt <= found_cnt + 16'd1;
      end
    end
  end

endmodule
